// File: rtl/axis_frame_packer.sv
// Serial-to-parallel AXIS frame packer: gathers BUS_NUM samples per output
// word and forces every frame to exactly FFT_SIZE samples (zero-pads short
// frames, drops the tail of long ones).
module axis_frame_packer #(
  parameter int unsigned FFT_SIZE = 8192,
  parameter int unsigned BUS_NUM  = 2,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WORD_AW  = $clog2(FFT_SIZE / BUS_NUM)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_tvalid,
  output logic                        s_tready,
  input  logic [DATA_W-1:0]           s_tdata,
  input  logic                        s_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [BUS_NUM*DATA_W-1:0]   m_tdata,
  output logic                        m_tlast,
  output logic                        err_short,
  output logic                        err_long,
  output logic                        frame_done
);

  localparam int unsigned          LANE_AW   = $clog2(BUS_NUM);
  localparam logic [LANE_AW-1:0]   LANE_LAST = LANE_AW'(BUS_NUM - 1);
  localparam logic [WORD_AW-1:0]   WORD_LAST = WORD_AW'(FFT_SIZE / BUS_NUM - 1);

  localparam logic [1:0] ST_FILL    = 2'd0;
  localparam logic [1:0] ST_PAD     = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  logic [1:0]                r_state;
  logic                      r_run;
  logic [LANE_AW-1:0]        r_lane;
  logic [WORD_AW-1:0]        r_word;
  logic [DATA_W-1:0]         r_asm [BUS_NUM];
  logic [BUS_NUM*DATA_W-1:0] r_out;
  logic                      r_mvalid;
  logic                      r_mlast;
  logic                      r_err_short;
  logic                      r_err_long;

  logic                      w_loadable;
  logic                      w_lane_last;
  logic                      w_word_last;
  logic                      w_completes;
  logic                      w_ready;
  logic                      w_acc;
  logic                      w_fill_acc;
  logic [BUS_NUM*DATA_W-1:0] w_word_data;

  assign w_loadable  = !r_mvalid || m_tready;
  assign w_lane_last = (r_lane == LANE_LAST);
  assign w_word_last = (r_word == WORD_LAST);
  assign w_completes = w_lane_last || s_tlast;
  assign w_acc       = s_tvalid && w_ready;
  assign w_fill_acc  = w_acc && (r_state == ST_FILL);

  // Input ready: stall only when this beat would finish a word into a full output reg.
  always_comb begin
    w_ready = 1'b0;
    if (r_run) begin
      case (r_state)
        ST_FILL:    w_ready = !(w_completes && !w_loadable);
        ST_DISCARD: w_ready = 1'b1;
        default:    w_ready = 1'b0;
      endcase
    end
  end

  // Word being completed: earlier lanes from assembly reg, current lane from input, later lanes zero.
  always_comb begin
    w_word_data = '0;
    for (int unsigned i = 0; i < BUS_NUM; i++) begin
      if (LANE_AW'(i) == r_lane)
        w_word_data[i*DATA_W +: DATA_W] = s_tdata;
      else if (LANE_AW'(i) < r_lane)
        w_word_data[i*DATA_W +: DATA_W] = r_asm[i];
    end
  end

  // Ready is held low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_run <= 1'b0;
    else        r_run <= 1'b1;
  end

  // Assembly register for partially filled word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUS_NUM; i++) r_asm[i] <= '0;
    end else if (w_fill_acc) begin
      r_asm[r_lane] <= s_tdata;
    end
  end

  // Frame FSM with lane/word counters and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_lane      <= '0;
      r_word      <= '0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
    end else begin
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      case (r_state)
        ST_FILL: begin
          if (w_acc) begin
            if (w_word_last && w_lane_last) begin
              r_lane <= '0;
              r_word <= '0;
              if (!s_tlast) begin
                r_err_long <= 1'b1;
                r_state    <= ST_DISCARD;
              end
            end else if (s_tlast) begin
              r_err_short <= 1'b1;
              r_lane      <= '0;
              if (w_word_last) begin
                r_word <= '0;
              end else begin
                r_word  <= r_word + WORD_AW'(1);
                r_state <= ST_PAD;
              end
            end else if (w_lane_last) begin
              r_lane <= '0;
              r_word <= r_word + WORD_AW'(1);
            end else begin
              r_lane <= r_lane + LANE_AW'(1);
            end
          end
        end
        ST_PAD: begin
          if (w_loadable) begin
            if (w_word_last) begin
              r_word  <= '0;
              r_state <= ST_FILL;
            end else begin
              r_word <= r_word + WORD_AW'(1);
            end
          end
        end
        ST_DISCARD: begin
          if (w_acc && s_tlast) begin
            r_lane  <= '0;
            r_word  <= '0;
            r_state <= ST_FILL;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  // Output register: loaded with a finished or padding word, cleared when drained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out    <= '0;
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
    end else if (w_fill_acc && w_completes) begin
      r_out    <= w_word_data;
      r_mvalid <= 1'b1;
      r_mlast  <= w_word_last;
    end else if ((r_state == ST_PAD) && w_loadable) begin
      r_out    <= '0;
      r_mvalid <= 1'b1;
      r_mlast  <= w_word_last;
    end else if (m_tready) begin
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
    end
  end

  assign s_tready   = w_ready;
  assign m_tvalid   = r_mvalid;
  assign m_tdata    = r_out;
  assign m_tlast    = r_mlast;
  assign err_short  = r_err_short;
  assign err_long   = r_err_long;
  assign frame_done = r_mvalid && m_tready && r_mlast;

endmodule

// File: tb/tb_axis_frame_packer.sv
// Testbench for axis_frame_packer: queue-based frame model, per-cycle compare.
module tb_axis_frame_packer;
  localparam int FFT = 16;
  localparam int BUS = 2;
  localparam int DW  = 32;
  localparam int NW  = FFT / BUS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_tvalid, s_tready, s_tlast;
  logic [DW-1:0]     s_tdata;
  logic              m_tvalid, m_tready, m_tlast;
  logic [BUS*DW-1:0] m_tdata;
  logic              err_short, err_long, frame_done;

  axis_frame_packer #(.FFT_SIZE(FFT), .BUS_NUM(BUS), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .err_short(err_short), .err_long(err_long), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [BUS*DW-1:0] d; logic l; } word_t;

  int checks = 0;
  int errors = 0;

  word_t         exp_q[$];
  word_t         out_log[$];
  logic [DW-1:0] mbuf[$];
  int            msamp = 0, mwords = 0;
  bit            mdiscard = 0, pend_short = 0, pend_long = 0;
  int            obs_short = 0, obs_long = 0, obs_done = 0, stall_cnt = 0;
  bit            prev_stall = 0;
  logic [BUS*DW-1:0] prev_d;
  logic          prev_l;
  word_t         mon_w;
  int            tr_mode = 0, tr_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Emit the word built from buffered lanes; unfilled lanes are zero.
  function automatic void push_word();
    word_t w;
    w.d = '0;
    for (int b = 0; b < mbuf.size(); b++) w.d[b*DW +: DW] = mbuf[b];
    w.l = (mwords == NW - 1);
    exp_q.push_back(w);
    mwords++;
    mbuf.delete();
  endfunction

  // Frame rules applied to each accepted sample.
  function automatic void model_accept(input logic [DW-1:0] d, input logic l);
    if (mdiscard) begin
      if (l) mdiscard = 0;
      return;
    end
    mbuf.push_back(d);
    msamp++;
    if (mbuf.size() == BUS || l) push_word();
    if (l || msamp == FFT) begin
      if (l && msamp < FFT) pend_short = 1;
      if (!l) begin pend_long = 1; mdiscard = 1; end
      while (mwords < NW) push_word();
      mwords = 0;
      msamp  = 0;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete(); mbuf.delete();
    msamp = 0; mwords = 0; mdiscard = 0; pend_short = 0; pend_long = 0; prev_stall = 0;
  endfunction

  // Compare process: everything sampled at negedge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("err_short", err_short, pend_short);
      chk("err_long", err_long, pend_long);
      pend_short = 0;
      pend_long  = 0;
      if (err_short) obs_short++;
      if (err_long)  obs_long++;
      if (prev_stall) begin
        chk("hold_valid", m_tvalid, 1'b1);
        chk("hold_data", m_tdata, prev_d);
        chk("hold_last", m_tlast, prev_l);
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word actual=%h required=none t=%0t", m_tdata, $time);
        end else begin
          mon_w = exp_q.pop_front();
          chk("m_tdata", m_tdata, mon_w.d);
          chk("m_tlast", m_tlast, mon_w.l);
          chk("frame_done", frame_done, mon_w.l);
        end
        mon_w.d = m_tdata; mon_w.l = m_tlast;
        out_log.push_back(mon_w);
      end else begin
        chk("frame_done_idle", frame_done, 1'b0);
      end
      if (frame_done) obs_done++;
      if (s_tvalid && !s_tready) stall_cnt++;
      if (s_tvalid && s_tready) model_accept(s_tdata, s_tlast);
    end
  end

  // Output-side ready pattern generator.
  always @(posedge clk) begin
    #1;
    tr_cnt++;
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = (tr_cnt < 10) ? 1'b0 : tr_cnt[0];
    endcase
  end

  function automatic logic [DW-1:0] kdata(input int k);
    return {16'(k), 16'(-k)};
  endfunction

  task automatic send_beat(input logic [DW-1:0] d, input logic l, input int gap);
    bit acc = 0;
    if (gap > 0) begin
      s_tvalid = 1'b0; s_tlast = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    s_tvalid = 1'b1; s_tdata = d; s_tlast = l;
    for (int c = 0; c < 500 && !acc; c++) begin
      @(negedge clk);
      if (s_tready) acc = 1;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL beat_timeout actual=no_accept required=accept t=%0t", $time);
    end
  endtask

  task automatic idle();
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic send_range(input int k0, input int k1, input int tl, input bit rnd);
    for (int k = k0; k < k1; k++)
      send_beat(rnd ? $urandom : kdata(k), k == tl,
                (rnd && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
  endtask

  task automatic wait_drain();
    bit done = 0;
    idle();
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !m_tvalid) done = 1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    out_log.delete();
    obs_short = 0; obs_long = 0; obs_done = 0; stall_cnt = 0;
  endtask

  initial begin
    int nlast;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; m_tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_tvalid", m_tvalid, 1'b0);
    chk("rst_s_tready", s_tready, 1'b0);
    chk("rst_m_tdata", m_tdata, 64'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // 1: exact frame, full throughput
    tr_mode = 0; clear_obs();
    send_range(0, 16, 15, 0); wait_drain();
    chk("t1_words", out_log.size(), 8);
    chk("t1_word3", out_log[3].d, 64'h0007_FFF9_0006_FFFA);
    chk("t1_last7", out_log[7].l, 1'b1);
    nlast = 0;
    foreach (out_log[i]) if (out_log[i].l) nlast++;
    chk("t1_nlast", nlast, 1);
    chk("t1_done", obs_done, 1);
    chk("t1_errs", obs_short + obs_long, 0);
    chk("t1_stall", stall_cnt, 0);

    // 2: short frame then normal frame
    clear_obs();
    send_range(0, 5, 4, 0); idle();
    @(negedge clk);
    chk("t2_pad_tready", s_tready, 1'b0);
    wait_drain();
    chk("t2_words", out_log.size(), 8);
    chk("t2_word2", out_log[2].d, 64'h0000_0000_0004_FFFC);
    chk("t2_word3", out_log[3].d, 64'h0);
    chk("t2_last7", out_log[7].l, 1'b1);
    chk("t2_short", obs_short, 1);
    clear_obs();
    send_range(0, 16, 15, 0); wait_drain();
    chk("t2_next_word0", out_log[0].d, 64'h0001_FFFF_0000_0000);

    // 3: long frame then normal frame
    clear_obs();
    send_range(0, 20, 19, 0); wait_drain();
    chk("t3_words", out_log.size(), 8);
    chk("t3_word7", out_log[7].d, 64'h000F_FFF1_000E_FFF2);
    chk("t3_long", obs_long, 1);
    send_range(0, 16, 15, 0); wait_drain();
    chk("t3_next_word0", out_log[8].d, 64'h0001_FFFF_0000_0000);
    chk("t3_total", out_log.size(), 16);

    // 4: back-to-back frames with output stalls
    clear_obs();
    send_range(0, 5, 15, 0);
    tr_cnt = 0; tr_mode = 2;
    send_range(5, 16, 15, 0);
    send_range(0, 16, 15, 0);
    wait_drain();
    chk("t4_words", out_log.size(), 16);
    chk("t4_done", obs_done, 2);
    tr_mode = 0;

    // 5: reset mid-frame
    clear_obs();
    send_range(0, 7, -1, 0);
    idle(); rst_n = 1'b0; model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("t5_rst_out", {s_tready, m_tvalid, m_tlast, err_short, err_long, frame_done}, 6'b0);
      chk("t5_rst_data", m_tdata, 64'h0);
    end
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    clear_obs();
    send_range(0, 16, 15, 0); wait_drain();
    chk("t5_words", out_log.size(), 8);
    chk("t5_word0", out_log[0].d, 64'h0001_FFFF_0000_0000);

    // 6: single-sample frame
    clear_obs();
    send_beat(32'h1234_5678, 1'b1, 0); wait_drain();
    chk("t6_words", out_log.size(), 8);
    chk("t6_word0", out_log[0].d, 64'h0000_0000_1234_5678);
    chk("t6_last7", out_log[7].l, 1'b1);
    chk("t6_short", obs_short, 1);

    // 7: random lengths, gaps and output backpressure
    tr_mode = 1;
    for (int f = 0; f < 30; f++) begin
      int len;
      len = $urandom_range(1, 24);
      send_range(0, len, len - 1, 1);
    end
    tr_mode = 0;
    wait_drain();
    chk("t7_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
